// File: rtl/rv_pkg.sv
// Shared definitions for the writeback slice: datapath width, register
// index width and the writeback result-source encodings.
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } result_src_e;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Bundle between the MEM stage / decode / hazard unit and the writeback
// controller. The slave side is the controller, the master side drives the
// MEM-stage, issue, cancel and query signals.
interface rf_writeback_ctrl_if #(
  parameter int XLEN = rv_pkg::XLEN
);
  import rv_pkg::*;

  // MEM stage
  logic                 valid_m;
  logic                 reg_write_m;
  logic [REG_IDX_W-1:0] rd_m;
  logic [1:0]           result_src_m;
  logic [XLEN-1:0]      alu_result_m;
  logic [XLEN-1:0]      read_data_m;
  logic [XLEN-1:0]      pc_plus4_m;
  // decode issue, flush cancel, hazard queries
  logic                 issue_we_d;
  logic [REG_IDX_W-1:0] issue_rd_d;
  logic                 cancel_we;
  logic [REG_IDX_W-1:0] cancel_rd;
  logic [REG_IDX_W-1:0] rs1_q;
  logic [REG_IDX_W-1:0] rs2_q;
  // register file write port and hazard status
  logic [REG_IDX_W-1:0] rd_w;
  logic                 we_w;
  logic [XLEN-1:0]      wd_w;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 sb_err;

  modport slave (
    input  valid_m, reg_write_m, rd_m, result_src_m,
    input  alu_result_m, read_data_m, pc_plus4_m,
    input  issue_we_d, issue_rd_d, cancel_we, cancel_rd, rs1_q, rs2_q,
    output rd_w, we_w, wd_w, rs1_busy, rs2_busy, sb_err
  );

  modport master (
    output valid_m, reg_write_m, rd_m, result_src_m,
    output alu_result_m, read_data_m, pc_plus4_m,
    output issue_we_d, issue_rd_d, cancel_we, cancel_rd, rs1_q, rs2_q,
    input  rd_w, we_w, wd_w, rs1_busy, rs2_busy, sb_err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters. Each register sums issue (+1),
// commit (-1) and cancel (-1) on one edge; results outside 0..max leave the
// counter unchanged and raise a sticky error. Register 0 is never tracked.
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int CNTW = 2,
  parameter int IW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_we,
  input  logic [IW-1:0] issue_rd,
  input  logic          commit_we,
  input  logic [IW-1:0] commit_rd,
  input  logic          cancel_we,
  input  logic [IW-1:0] cancel_rd,
  input  logic [IW-1:0] rs1_q,
  input  logic [IW-1:0] rs2_q,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          sb_err
);

  // signed sum width: counter range plus room for +1 and -2
  localparam int SW = CNTW + 2;
  localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNTW) - 1);

  logic [CNTW-1:0] cnt_reg [NREG];
  logic [NREG-1:0] err_hit;
  logic            sb_err_reg;

  assign cnt_reg[0] = '0;
  assign err_hit[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      logic                 inc;
      logic                 dec_commit;
      logic                 dec_cancel;
      logic signed [SW-1:0] sum;
      logic                 over;
      logic                 under;

      // net change for this register from all three event sources
      always_comb begin
        inc        = issue_we  & (issue_rd  == IW'(gi));
        dec_commit = commit_we & (commit_rd == IW'(gi));
        dec_cancel = cancel_we & (cancel_rd == IW'(gi));
        sum        = SW'(cnt_reg[gi]) + SW'(inc) - SW'(dec_commit) - SW'(dec_cancel);
        over       = (sum > CNT_MAX);
        under      = sum[SW-1];
      end

      assign err_hit[gi] = over | under;

      // apply the delta unless it would leave the representable range
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (!over && !under) begin
          cnt_reg[gi] <= sum[CNTW-1:0];
        end
      end
    end
  endgenerate

  // sticky error, only reset clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_err_reg <= 1'b0;
    end else if (|err_hit) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err   = sb_err_reg;
  assign rs1_busy = (cnt_reg[rs1_q] != '0);
  assign rs2_busy = (cnt_reg[rs2_q] != '0);

endmodule

// File: rtl/rf_writeback_ctrl.sv
// MEM/WB pipeline register and result mux driving the register file write
// port. The registered write also acts as the commit event for the
// pending-write scoreboard, so both see it on the same edge.
module rf_writeback_ctrl #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input logic               clk,
  input logic               rst,
  rf_writeback_ctrl_if.slave bus
);
  import rv_pkg::*;

  logic [REG_IDX_W-1:0] rd_w_reg;
  logic                 we_w_reg;
  logic [XLEN-1:0]      wd_w_reg;
  logic                 we_next;
  logic [XLEN-1:0]      wd_next;

  // writes to x0 are suppressed here so they never reach the file or scoreboard
  always_comb begin
    we_next = bus.valid_m & bus.reg_write_m & (bus.rd_m != '0);
    case (result_src_e'(bus.result_src_m))
      RES_ALU: wd_next = bus.alu_result_m;
      RES_MEM: wd_next = bus.read_data_m;
      RES_PC4: wd_next = bus.pc_plus4_m;
      default: wd_next = '0;
    endcase
  end

  // MEM/WB register; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_w_reg <= '0;
      we_w_reg <= 1'b0;
      wd_w_reg <= '0;
    end else begin
      rd_w_reg <= bus.rd_m;
      we_w_reg <= we_next;
      wd_w_reg <= wd_next;
    end
  end

  assign bus.rd_w = rd_w_reg;
  assign bus.we_w = we_w_reg;
  assign bus.wd_w = wd_w_reg;

  rf_scoreboard #(
    .NREG (NREG),
    .CNTW (CNTW),
    .IW   (REG_IDX_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue_we  (bus.issue_we_d),
    .issue_rd  (bus.issue_rd_d),
    .commit_we (we_w_reg),
    .commit_rd (rd_w_reg),
    .cancel_we (bus.cancel_we),
    .cancel_rd (bus.cancel_rd),
    .rs1_q     (bus.rs1_q),
    .rs2_q     (bus.rs2_q),
    .rs1_busy  (bus.rs1_busy),
    .rs2_busy  (bus.rs2_busy),
    .sb_err    (bus.sb_err)
  );

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rf_writeback_ctrl;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_ctrl_if bus();

  rf_writeback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // behavioural model state
  int          m_cnt [32];
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.valid_m      = 1'b0;
    bus.reg_write_m  = 1'b0;
    bus.rd_m         = '0;
    bus.result_src_m = 2'b00;
    bus.alu_result_m = '0;
    bus.read_data_m  = '0;
    bus.pc_plus4_m   = '0;
    bus.issue_we_d   = 1'b0;
    bus.issue_rd_d   = '0;
    bus.cancel_we    = 1'b0;
    bus.cancel_rd    = '0;
  endtask

  // model of one clock edge, using the inputs as they stand at the edge
  task automatic model_edge();
    int d;
    int n;
    if (!rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
      m_we  = 0;
      m_rd  = '0;
      m_wd  = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        d = 0;
        if (bus.issue_we_d && bus.issue_rd_d == 5'(r)) d = d + 1;
        if (m_we && m_rd == 5'(r))                     d = d - 1;
        if (bus.cancel_we && bus.cancel_rd == 5'(r))   d = d - 1;
        n = m_cnt[r] + d;
        if (n > 3)      m_err = 1;
        else if (n < 0) m_err = 1;
        else            m_cnt[r] = n;
      end
      m_we = bus.valid_m && bus.reg_write_m && (bus.rd_m != 0);
      m_rd = bus.rd_m;
      case (bus.result_src_m)
        2'b00:   m_wd = bus.alu_result_m;
        2'b01:   m_wd = bus.read_data_m;
        2'b10:   m_wd = bus.pc_plus4_m;
        default: m_wd = 32'h0;
      endcase
    end
  endtask

  // compare every meaningful output against the model
  task automatic model_check();
    chk("we_w", 32'(bus.we_w), 32'(m_we));
    if (m_we) begin
      chk("rd_w", 32'(bus.rd_w), 32'(m_rd));
      chk("wd_w", bus.wd_w, m_wd);
    end
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(m_cnt[bus.rs1_q] != 0));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(m_cnt[bus.rs2_q] != 0));
    chk("sb_err", 32'(bus.sb_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    model_check();
    $display("cyc %0d rst=%0b we_w=%0b rd_w=%0d wd_w=0x%0h busy=%0b%0b sb_err=%0b",
             cyc, rst, bus.we_w, bus.rd_w, bus.wd_w, bus.rs1_busy, bus.rs2_busy, bus.sb_err);
  endtask

  function automatic logic [4:0] pick_rd();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  logic [31:0] exp_mux [4];

  initial begin
    exp_mux[0] = 32'h11;
    exp_mux[1] = 32'h22;
    exp_mux[2] = 32'h33;
    exp_mux[3] = 32'h0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0; m_we = 0; m_rd = '0; m_wd = '0;
    idle();
    bus.rs1_q = '0;
    bus.rs2_q = '0;

    // reset holds everything at zero despite active inputs
    rst = 1'b0;
    bus.valid_m = 1'b1; bus.reg_write_m = 1'b1; bus.rd_m = 5'd5;
    bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd5;
    bus.rs1_q = 5'd5;
    tick();
    tick();
    chk("reset_we_w", 32'(bus.we_w), 32'h0);
    chk("reset_rd_w", 32'(bus.rd_w), 32'h0);
    chk("reset_busy", 32'(bus.rs1_busy), 32'h0);
    chk("reset_sb_err", 32'(bus.sb_err), 32'h0);
    rst = 1'b1;
    idle();
    tick();

    // x0 guard
    bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd0;
    bus.valid_m = 1'b1; bus.reg_write_m = 1'b1; bus.rd_m = 5'd0;
    bus.rs1_q = 5'd0;
    tick();
    chk("x0_we_w", 32'(bus.we_w), 32'h0);
    chk("x0_busy", 32'(bus.rs1_busy), 32'h0);
    idle();
    tick();
    chk("x0_sb_err", 32'(bus.sb_err), 32'h0);

    // scoreboard lifecycle on x3
    bus.rs1_q = 5'd3;
    bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd3;
    tick();
    chk("life_busy_c1", 32'(bus.rs1_busy), 32'h1);
    idle();
    tick();
    tick();
    bus.valid_m = 1'b1; bus.reg_write_m = 1'b1; bus.rd_m = 5'd3;
    bus.alu_result_m = 32'hABCD;
    tick();
    chk("life_we_w_c4", 32'(bus.we_w), 32'h1);
    chk("life_busy_c4", 32'(bus.rs1_busy), 32'h1);
    idle();
    tick();
    chk("life_busy_c5", 32'(bus.rs1_busy), 32'h0);

    // simultaneous issue and commit on x9, then cancel
    bus.rs1_q = 5'd9;
    bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd9;
    tick();
    idle();
    bus.valid_m = 1'b1; bus.reg_write_m = 1'b1; bus.rd_m = 5'd9;
    tick();
    idle();
    bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd9;
    tick();
    chk("simul_busy", 32'(bus.rs1_busy), 32'h1);
    chk("simul_sb_err", 32'(bus.sb_err), 32'h0);
    idle();
    bus.cancel_we = 1'b1; bus.cancel_rd = 5'd9;
    tick();
    chk("cancel_busy", 32'(bus.rs1_busy), 32'h0);
    idle();
    tick();

    // result mux sweep (the resulting commits underflow; reset follows)
    for (int s = 0; s < 4; s++) begin
      bus.valid_m = 1'b1; bus.reg_write_m = 1'b1; bus.rd_m = 5'd7;
      bus.alu_result_m = 32'h11; bus.read_data_m = 32'h22; bus.pc_plus4_m = 32'h33;
      bus.result_src_m = 2'(s);
      tick();
      chk($sformatf("mux_wd_src%0d", s), bus.wd_w, exp_mux[s]);
      chk($sformatf("mux_we_src%0d", s), 32'(bus.we_w), 32'h1);
      chk($sformatf("mux_rd_src%0d", s), 32'(bus.rd_w), 32'h7);
    end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // saturation: four issues to x4
    bus.rs1_q = 5'd4;
    bus.rs2_q = 5'd12;
    for (int k = 0; k < 4; k++) begin
      bus.issue_we_d = 1'b1; bus.issue_rd_d = 5'd4;
      tick();
      chk($sformatf("sat_err_issue%0d", k + 1), 32'(bus.sb_err), (k == 3) ? 32'h1 : 32'h0);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      bus.cancel_we = 1'b1; bus.cancel_rd = 5'd4;
      tick();
      chk($sformatf("sat_busy_cancel%0d", k + 1), 32'(bus.rs1_busy), (k == 2) ? 32'h0 : 32'h1);
    end
    bus.cancel_we = 1'b1; bus.cancel_rd = 5'd12;
    tick();
    chk("underflow_err", 32'(bus.sb_err), 32'h1);
    chk("underflow_busy", 32'(bus.rs2_busy), 32'h0);
    idle();
    tick();
    chk("err_sticky", 32'(bus.sb_err), 32'h1);
    rst = 1'b0;
    tick();
    chk("err_cleared", 32'(bus.sb_err), 32'h0);
    rst = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst              = ($urandom_range(0, 99) != 0);
      bus.valid_m      = $urandom_range(0, 1) == 1;
      bus.reg_write_m  = $urandom_range(0, 3) != 0;
      bus.rd_m         = pick_rd();
      bus.result_src_m = 2'($urandom_range(0, 3));
      bus.alu_result_m = $urandom;
      bus.read_data_m  = $urandom;
      bus.pc_plus4_m   = $urandom;
      bus.issue_we_d   = $urandom_range(0, 1) == 1;
      bus.issue_rd_d   = pick_rd();
      bus.cancel_we    = $urandom_range(0, 4) == 0;
      bus.cancel_rd    = pick_rd();
      bus.rs1_q        = pick_rd();
      bus.rs2_q        = pick_rd();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
